// File: rtl/rob_commit_unit.sv
// -----------------------------------------------------------------------------
// rob_commit_unit
//   Circular reorder buffer for the Tomasulo RISC-V core. Tags are allocated at
//   issue, results are collected from the ALU and LSB result buses, and at most
//   one instruction retires per cycle in program order. Tag 0 means
//   "no dependency", so live tags run 1..ROB_DEPTH and entry 0 is never used.
//
//   Ports
//     clk_in, rst_in (async, active-low), rdy_in (low = freeze all state)
//     issue_*        : allocation request; rob_next_index / rob_full report the
//                      tag the next issue receives and whether a slot is free
//     alu_*, lsb_*   : result buses (ALU has priority on a tag collision)
//     dc_rs*_query   : operand probes -> rob_rs*_ready / rob_rs*_val
//     rob_to_reg_*   : register-file commit port (one-cycle pulse)
//     rob_to_lsb_*   : store-commit permission for the head store
//     rob_clr_out, rob_redirect_pc : pipeline flush on branch mispredict
//
//   Build option: define ROB_BYPASS_EN to let the query ports forward
//   same-cycle result-bus data.
// -----------------------------------------------------------------------------
module rob_commit_unit #(
    parameter int ROB_DEPTH = 15,
    parameter int ROB_IDX_W = 4,
    parameter int XLEN      = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic [1:0]           issue_type,
    input  logic [XLEN-1:0]      issue_pc,
    input  logic                 issue_pred_jump,
    input  logic                 issue_done,
    input  logic [XLEN-1:0]      issue_val,
    output logic [ROB_IDX_W-1:0] rob_next_index,
    output logic                 rob_full,
    input  logic                 alu_valid,
    input  logic [ROB_IDX_W-1:0] alu_rob_index,
    input  logic [XLEN-1:0]      alu_val,
    input  logic                 alu_jump,
    input  logic [XLEN-1:0]      alu_target,
    input  logic                 lsb_valid,
    input  logic [ROB_IDX_W-1:0] lsb_rob_index,
    input  logic [XLEN-1:0]      lsb_val,
    input  logic [ROB_IDX_W-1:0] dc_rs1_query,
    input  logic [ROB_IDX_W-1:0] dc_rs2_query,
    output logic                 rob_rs1_ready,
    output logic                 rob_rs2_ready,
    output logic [XLEN-1:0]      rob_rs1_val,
    output logic [XLEN-1:0]      rob_rs2_val,
    output logic                 rob_to_reg_commit,
    output logic [ROB_IDX_W-1:0] rob_to_reg_rob_index,
    output logic [4:0]           rob_to_reg_index,
    output logic [XLEN-1:0]      rob_to_reg_val,
    output logic                 rob_to_lsb_store_commit,
    output logic [ROB_IDX_W-1:0] rob_to_lsb_rob_index,
    output logic                 rob_clr_out,
    output logic [XLEN-1:0]      rob_redirect_pc
);
    localparam logic [1:0] TYPE_REG    = 2'd0;
    localparam logic [1:0] TYPE_BRANCH = 2'd1;
    localparam logic [1:0] TYPE_STORE  = 2'd2;
    localparam logic [ROB_IDX_W-1:0] TAG_FIRST = ROB_IDX_W'(1);
    localparam logic [ROB_IDX_W-1:0] TAG_LAST  = ROB_IDX_W'(ROB_DEPTH);

    // Control state (reset) and payload (no reset; only meaningful while busy)
    logic [ROB_IDX_W-1:0] head_reg, head_next, tail_reg, tail_next;
    logic [ROB_IDX_W-1:0] count_reg, count_next;
    logic [ROB_DEPTH:0]   busy_reg, busy_next, ready_reg, ready_next;
    logic [4:0]           rd_reg     [0:ROB_DEPTH];
    logic [1:0]           type_reg   [0:ROB_DEPTH];
    logic [XLEN-1:0]      pc_reg     [0:ROB_DEPTH];
    logic [XLEN-1:0]      val_reg    [0:ROB_DEPTH];
    logic [XLEN-1:0]      target_reg [0:ROB_DEPTH];
    logic                 pred_reg   [0:ROB_DEPTH];
    logic                 jump_reg   [0:ROB_DEPTH];

    function automatic logic [ROB_IDX_W-1:0] next_tag(input logic [ROB_IDX_W-1:0] t);
        return (t == TAG_LAST) ? TAG_FIRST : t + TAG_FIRST;
    endfunction

    logic issue_fire, commit_fire, mispredict;
    logic [ROB_DEPTH:0] issue_hit, alu_hit, lsb_hit;

    assign rob_full       = (count_reg == TAG_LAST);
    assign rob_next_index = tail_reg;
    assign issue_fire     = issue_valid && !rob_full;
    // Commit looks only at state registered before this edge, so a bus write
    // in cycle N retires in cycle N+1 at the earliest.
    assign commit_fire    = busy_reg[head_reg] && ready_reg[head_reg];
    assign mispredict     = commit_fire && (type_reg[head_reg] == TYPE_BRANCH) &&
                            (jump_reg[head_reg] != pred_reg[head_reg]);

    // Per-entry write strobes. Bus writes only land on busy entries; the LSB
    // bus is masked when the ALU names the same entry.
    assign issue_hit[0] = 1'b0;
    assign alu_hit[0]   = 1'b0;
    assign lsb_hit[0]   = 1'b0;
    generate
        for (genvar gi = 1; gi <= ROB_DEPTH; gi++) begin : g_hit
            assign issue_hit[gi] = issue_fire && (tail_reg == ROB_IDX_W'(gi));
            assign alu_hit[gi]   = alu_valid && (alu_rob_index == ROB_IDX_W'(gi)) && busy_reg[gi];
            assign lsb_hit[gi]   = lsb_valid && (lsb_rob_index == ROB_IDX_W'(gi)) && busy_reg[gi] &&
                                   !alu_hit[gi];
        end
    endgenerate

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        busy_next  = busy_reg;
        ready_next = ready_reg;
        if (mispredict) begin
            // Flush beats any same-cycle issue.
            head_next  = TAG_FIRST;
            tail_next  = TAG_FIRST;
            count_next = '0;
            busy_next  = '0;
            ready_next = '0;
        end else begin
            if (commit_fire) begin
                head_next           = next_tag(head_reg);
                busy_next[head_reg] = 1'b0;
            end
            if (issue_fire) begin
                tail_next            = next_tag(tail_reg);
                busy_next[tail_reg]  = 1'b1;
                ready_next[tail_reg] = issue_done;
            end
            ready_next = ready_next | alu_hit | lsb_hit;
            count_next = count_reg + ROB_IDX_W'(issue_fire) - ROB_IDX_W'(commit_fire);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_reg                <= TAG_FIRST;
            tail_reg                <= TAG_FIRST;
            count_reg               <= '0;
            busy_reg                <= '0;
            ready_reg               <= '0;
            rob_to_reg_commit       <= 1'b0;
            rob_to_reg_rob_index    <= '0;
            rob_to_reg_index        <= '0;
            rob_to_reg_val          <= '0;
            rob_to_lsb_store_commit <= 1'b0;
            rob_to_lsb_rob_index    <= '0;
            rob_clr_out             <= 1'b0;
            rob_redirect_pc         <= '0;
        end else if (rdy_in) begin
            head_reg                <= head_next;
            tail_reg                <= tail_next;
            count_reg               <= count_next;
            busy_reg                <= busy_next;
            ready_reg               <= ready_next;
            rob_to_reg_commit       <= 1'b0;
            rob_to_lsb_store_commit <= 1'b0;
            rob_clr_out             <= 1'b0;
            if (commit_fire) begin
                // Branches with a link register write it like a REG op.
                if (type_reg[head_reg] == TYPE_REG ||
                    (type_reg[head_reg] == TYPE_BRANCH && rd_reg[head_reg] != 5'd0)) begin
                    rob_to_reg_commit    <= 1'b1;
                    rob_to_reg_rob_index <= head_reg;
                    rob_to_reg_index     <= rd_reg[head_reg];
                    rob_to_reg_val       <= val_reg[head_reg];
                end
                if (type_reg[head_reg] == TYPE_STORE) begin
                    rob_to_lsb_store_commit <= 1'b1;
                    rob_to_lsb_rob_index    <= head_reg;
                end
                if (mispredict) begin
                    rob_clr_out     <= 1'b1;
                    rob_redirect_pc <= jump_reg[head_reg] ? target_reg[head_reg]
                                                          : pc_reg[head_reg] + XLEN'(4);
                end
            end
        end
    end

    // Payload storage. At issue the resolved direction defaults to the
    // prediction, so a branch that is already complete at issue never flushes.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            for (int i = 0; i <= ROB_DEPTH; i++) begin
                if (issue_hit[i]) begin
                    rd_reg[i]   <= issue_rd;
                    type_reg[i] <= issue_type;
                    pc_reg[i]   <= issue_pc;
                    pred_reg[i] <= issue_pred_jump;
                    jump_reg[i] <= issue_pred_jump;
                    val_reg[i]  <= issue_val;
                end else if (alu_hit[i]) begin
                    val_reg[i]    <= alu_val;
                    jump_reg[i]   <= alu_jump;
                    target_reg[i] <= alu_target;
                end else if (lsb_hit[i]) begin
                    val_reg[i] <= lsb_val;
                end
            end
        end
    end

    // Operand probes: two identical lookups.
    logic [ROB_IDX_W-1:0] q_tag   [2];
    logic                 q_ready [2];
    logic [XLEN-1:0]      q_val   [2];
    assign q_tag[0] = dc_rs1_query;
    assign q_tag[1] = dc_rs2_query;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            q_ready[k] = 1'b0;
            q_val[k]   = '0;
            if (q_tag[k] != '0 && q_tag[k] <= TAG_LAST && busy_reg[q_tag[k]]) begin
                q_ready[k] = ready_reg[q_tag[k]];
                q_val[k]   = val_reg[q_tag[k]];
`ifdef ROB_BYPASS_EN
                if (alu_valid && alu_rob_index == q_tag[k]) begin
                    q_ready[k] = 1'b1;
                    q_val[k]   = alu_val;
                end else if (lsb_valid && lsb_rob_index == q_tag[k]) begin
                    q_ready[k] = 1'b1;
                    q_val[k]   = lsb_val;
                end
`endif
            end
        end
    end

    assign rob_rs1_ready = q_ready[0];
    assign rob_rs1_val   = q_val[0];
    assign rob_rs2_ready = q_ready[1];
    assign rob_rs2_val   = q_val[1];

endmodule

// File: tb/tb_rob_commit_unit.sv
// -----------------------------------------------------------------------------
// tb_rob_commit_unit
//   Scenario tasks drive the reorder buffer; every expected retirement (REG,
//   STORE or flush) is pushed to a queue when its stimulus is driven, and a
//   monitor on the falling edge pops and compares each commit pulse.
// -----------------------------------------------------------------------------
module tb_rob_commit_unit;
    localparam int DEPTH = 15;
    localparam int W     = 4;
    localparam int XLEN  = 32;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b1;
    logic            rdy_in = 1'b1;
    logic            issue_valid = 1'b0;
    logic [4:0]      issue_rd = '0;
    logic [1:0]      issue_type = '0;
    logic [XLEN-1:0] issue_pc = '0;
    logic            issue_pred_jump = 1'b0;
    logic            issue_done = 1'b0;
    logic [XLEN-1:0] issue_val = '0;
    logic [W-1:0]    rob_next_index;
    logic            rob_full;
    logic            alu_valid = 1'b0;
    logic [W-1:0]    alu_rob_index = '0;
    logic [XLEN-1:0] alu_val = '0;
    logic            alu_jump = 1'b0;
    logic [XLEN-1:0] alu_target = '0;
    logic            lsb_valid = 1'b0;
    logic [W-1:0]    lsb_rob_index = '0;
    logic [XLEN-1:0] lsb_val = '0;
    logic [W-1:0]    dc_rs1_query = '0;
    logic [W-1:0]    dc_rs2_query = '0;
    logic            rob_rs1_ready, rob_rs2_ready;
    logic [XLEN-1:0] rob_rs1_val, rob_rs2_val;
    logic            rob_to_reg_commit;
    logic [W-1:0]    rob_to_reg_rob_index;
    logic [4:0]      rob_to_reg_index;
    logic [XLEN-1:0] rob_to_reg_val;
    logic            rob_to_lsb_store_commit;
    logic [W-1:0]    rob_to_lsb_rob_index;
    logic            rob_clr_out;
    logic [XLEN-1:0] rob_redirect_pc;

    always #5 clk_in = ~clk_in;

    rob_commit_unit #(.ROB_DEPTH(DEPTH), .ROB_IDX_W(W), .XLEN(XLEN)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_type(issue_type),
        .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump),
        .issue_done(issue_done), .issue_val(issue_val),
        .rob_next_index(rob_next_index), .rob_full(rob_full),
        .alu_valid(alu_valid), .alu_rob_index(alu_rob_index), .alu_val(alu_val),
        .alu_jump(alu_jump), .alu_target(alu_target),
        .lsb_valid(lsb_valid), .lsb_rob_index(lsb_rob_index), .lsb_val(lsb_val),
        .dc_rs1_query(dc_rs1_query), .dc_rs2_query(dc_rs2_query),
        .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
        .rob_rs1_val(rob_rs1_val), .rob_rs2_val(rob_rs2_val),
        .rob_to_reg_commit(rob_to_reg_commit), .rob_to_reg_rob_index(rob_to_reg_rob_index),
        .rob_to_reg_index(rob_to_reg_index), .rob_to_reg_val(rob_to_reg_val),
        .rob_to_lsb_store_commit(rob_to_lsb_store_commit),
        .rob_to_lsb_rob_index(rob_to_lsb_rob_index),
        .rob_clr_out(rob_clr_out), .rob_redirect_pc(rob_redirect_pc)
    );

    // kind: 0 = register commit, 1 = flush/redirect, 2 = store commit
    typedef struct {
        int           kind;
        logic [W-1:0] tag;
        logic [4:0]   rd;
        logic [31:0]  val;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] tail_m = 4'd1;

    function automatic logic [W-1:0] nxt(input logic [W-1:0] t);
        return (t == 4'(DEPTH)) ? 4'd1 : t + 4'd1;
    endfunction

    function automatic exp_t mk(input int kind, input logic [W-1:0] tag,
                                input logic [4:0] rd, input logic [31:0] val);
        exp_t e;
        e.kind = kind; e.tag = tag; e.rd = rd; e.val = val;
        return e;
    endfunction

    // Scoreboard monitor
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_in) begin
            if (rob_to_reg_commit) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL reg_commit_unexpected: got tag %0d x%0d=%h, expected no commit",
                             rob_to_reg_rob_index, rob_to_reg_index, rob_to_reg_val);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != 0 || rob_to_reg_rob_index !== e.tag ||
                        rob_to_reg_index !== e.rd || rob_to_reg_val !== e.val) begin
                        errors++;
                        $display("FAIL reg_commit: got tag %0d x%0d=%h, expected kind %0d tag %0d x%0d=%h",
                                 rob_to_reg_rob_index, rob_to_reg_index, rob_to_reg_val,
                                 e.kind, e.tag, e.rd, e.val);
                    end else
                        $display("commit reg   tag %0d x%0d=%h", e.tag, e.rd, e.val);
                end
            end
            if (rob_to_lsb_store_commit) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL store_commit_unexpected: got tag %0d, expected no commit",
                             rob_to_lsb_rob_index);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != 2 || rob_to_lsb_rob_index !== e.tag) begin
                        errors++;
                        $display("FAIL store_commit: got tag %0d, expected kind %0d tag %0d",
                                 rob_to_lsb_rob_index, e.kind, e.tag);
                    end else
                        $display("commit store tag %0d", e.tag);
                end
            end
            if (rob_clr_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL clear_unexpected: got redirect %h, expected no flush", rob_redirect_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != 1 || rob_redirect_pc !== e.val) begin
                        errors++;
                        $display("FAIL clear: got redirect %h, expected kind %0d redirect %h",
                                 rob_redirect_pc, e.kind, e.val);
                    end else
                        $display("flush        redirect %h", e.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [1:0] typ, input logic [31:0] pc,
                            input logic pred, input logic done, input logic [31:0] v);
        issue_valid = 1'b1; issue_rd = rd; issue_type = typ; issue_pc = pc;
        issue_pred_jump = pred; issue_done = done; issue_val = v;
        tick();
        issue_valid = 1'b0;
        tail_m = nxt(tail_m);
    endtask

    task automatic alu_write(input logic [W-1:0] tag, input logic [31:0] v,
                             input logic jmp, input logic [31:0] tgt);
        alu_valid = 1'b1; alu_rob_index = tag; alu_val = v; alu_jump = jmp; alu_target = tgt;
        tick();
        alu_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (2) tick();
        checks++; if (rob_next_index !== 4'd1) begin errors++; $display("FAIL reset_next_index: got %0d expected 1", rob_next_index); end
        checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", rob_full); end
        checks++; if ({rob_to_reg_commit, rob_to_lsb_store_commit, rob_clr_out} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b expected 000", {rob_to_reg_commit, rob_to_lsb_store_commit, rob_clr_out}); end
        checks++; if (rob_redirect_pc !== 32'd0) begin errors++; $display("FAIL reset_redirect: got %h expected 0", rob_redirect_pc); end
        rst_in = 1'b1;
        tail_m = 4'd1;
        tick();
    endtask

    task automatic test_issue_order();
        for (int i = 0; i < 3; i++) begin
            checks++; if (rob_next_index !== tail_m) begin errors++; $display("FAIL issue_tag: got %0d expected %0d", rob_next_index, tail_m); end
            do_issue(5'(5 + i), 2'd0, 32'h10 + 32'(4 * i), 1'b0, 1'b0, 32'd0);
        end
        checks++; if (rob_next_index !== 4'd4) begin errors++; $display("FAIL issue_next4: got %0d expected 4", rob_next_index); end
        alu_write(4'd2, 32'h22, 1'b0, 32'd0);
        dc_rs1_query = 4'd2; dc_rs2_query = 4'd3; #1;
        checks++; if (rob_rs1_ready !== 1'b1 || rob_rs1_val !== 32'h22) begin
            errors++; $display("FAIL query_ready: got %b/%h expected 1/00000022", rob_rs1_ready, rob_rs1_val); end
        checks++; if (rob_rs2_ready !== 1'b0 || rob_rs2_val !== 32'd0) begin
            errors++; $display("FAIL query_pending: got %b/%h expected 0/00000000", rob_rs2_ready, rob_rs2_val); end
        exp_q.push_back(mk(0, 4'd1, 5'd5, 32'h11));
        exp_q.push_back(mk(0, 4'd2, 5'd6, 32'h22));
        alu_write(4'd1, 32'h11, 1'b0, 32'd0);
        checks++; if (rob_to_reg_commit !== 1'b0) begin errors++; $display("FAIL early_commit: got %b expected 0", rob_to_reg_commit); end
        tick();
        checks++; if (rob_to_reg_commit !== 1'b1 || rob_to_reg_rob_index !== 4'd1) begin
            errors++; $display("FAIL commit_tag1: got %b/%0d expected 1/1", rob_to_reg_commit, rob_to_reg_rob_index); end
        tick();
        checks++; if (rob_to_reg_commit !== 1'b1 || rob_to_reg_rob_index !== 4'd2) begin
            errors++; $display("FAIL commit_tag2: got %b/%0d expected 1/2", rob_to_reg_commit, rob_to_reg_rob_index); end
        tick();
        checks++; if (rob_to_reg_commit !== 1'b0) begin errors++; $display("FAIL tag3_held: got %b expected 0", rob_to_reg_commit); end
        exp_q.push_back(mk(0, 4'd3, 5'd7, 32'h33));
        alu_write(4'd3, 32'h33, 1'b0, 32'd0);
        repeat (2) tick();
    endtask

    task automatic test_rdy_hold();
        rdy_in = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd1;
        tick();
        issue_valid = 1'b0;
        checks++; if (rob_next_index !== tail_m) begin errors++; $display("FAIL rdy_hold: got %0d expected %0d", rob_next_index, tail_m); end
        rdy_in = 1'b1;
        tick();
    endtask

    task automatic test_full();
        logic [W-1:0] t;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (rob_next_index !== tail_m || rob_next_index == 4'd0) begin
                errors++; $display("FAIL fill_tag: got %0d expected %0d", rob_next_index, tail_m); end
            do_issue({1'b0, tail_m}, 2'd0, 32'h1000, 1'b0, 1'b0, 32'd0);
        end
        checks++; if (rob_full !== 1'b1 || rob_next_index !== 4'd4) begin
            errors++; $display("FAIL full: got %b/%0d expected 1/4", rob_full, rob_next_index); end
        issue_valid = 1'b1; issue_rd = 5'd31;
        tick();
        issue_valid = 1'b0;
        checks++; if (rob_full !== 1'b1 || rob_next_index !== 4'd4) begin
            errors++; $display("FAIL full_ignore: got %b/%0d expected 1/4", rob_full, rob_next_index); end
        exp_q.push_back(mk(0, 4'd4, 5'd4, 32'h1004));
        alu_write(4'd4, 32'h1004, 1'b0, 32'd0);
        exp_q.push_back(mk(0, 4'd5, 5'd5, 32'h1005));
        alu_write(4'd5, 32'h1005, 1'b0, 32'd0);
        checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL full_after_commit: got %b expected 0", rob_full); end
        do_issue(5'd20, 2'd0, 32'h2000, 1'b0, 1'b0, 32'd0);   // tag 5 commits in this cycle
        checks++; if (rob_full !== 1'b0 || rob_next_index !== 4'd5) begin
            errors++; $display("FAIL issue_and_commit: got %b/%0d expected 0/5", rob_full, rob_next_index); end
        do_issue(5'd21, 2'd0, 32'h2004, 1'b0, 1'b0, 32'd0);
        checks++; if (rob_full !== 1'b1) begin errors++; $display("FAIL refill: got %b expected 1", rob_full); end
        t = 4'd6;
        for (int k = 0; k < DEPTH; k++) begin
            if (t == 4'd4)      begin exp_q.push_back(mk(0, t, 5'd20, 32'h2004)); alu_write(t, 32'h2004, 1'b0, 32'd0); end
            else if (t == 4'd5) begin exp_q.push_back(mk(0, t, 5'd21, 32'h2005)); alu_write(t, 32'h2005, 1'b0, 32'd0); end
            else begin exp_q.push_back(mk(0, t, {1'b0, t}, 32'h1000 + 32'(t))); alu_write(t, 32'h1000 + 32'(t), 1'b0, 32'd0); end
            t = nxt(t);
        end
        repeat (2) tick();
    endtask

    task automatic test_mispredict();
        do_issue(5'd0, 2'd1, 32'h100, 1'b0, 1'b0, 32'd0);     // tag 6
        do_issue(5'd12, 2'd0, 32'h104, 1'b0, 1'b0, 32'd0);    // tag 7
        do_issue(5'd13, 2'd0, 32'h108, 1'b0, 1'b0, 32'd0);    // tag 8
        exp_q.push_back(mk(1, 4'd6, 5'd0, 32'h200));
        lsb_valid = 1'b1; lsb_rob_index = 4'd7; lsb_val = 32'h77;
        alu_write(4'd6, 32'd0, 1'b1, 32'h200);
        lsb_valid = 1'b0;
        checks++; if (rob_clr_out !== 1'b0) begin errors++; $display("FAIL early_clear: got %b expected 0", rob_clr_out); end
        tick();
        tail_m = 4'd1;
        dc_rs1_query = 4'd7; #1;
        checks++; if (rob_clr_out !== 1'b1 || rob_redirect_pc !== 32'h200) begin
            errors++; $display("FAIL mispredict: got %b/%h expected 1/00000200", rob_clr_out, rob_redirect_pc); end
        checks++; if (rob_next_index !== 4'd1) begin errors++; $display("FAIL flush_tail: got %0d expected 1", rob_next_index); end
        checks++; if (rob_rs1_ready !== 1'b0) begin errors++; $display("FAIL flush_entries: got %b expected 0", rob_rs1_ready); end
        tick();
        checks++; if (rob_clr_out !== 1'b0) begin errors++; $display("FAIL clear_pulse: got %b expected 0", rob_clr_out); end
    endtask

    task automatic test_store();
        do_issue(5'd3, 2'd2, 32'h300, 1'b0, 1'b0, 32'd0);     // tag 1
        do_issue(5'd9, 2'd1, 32'h300, 1'b1, 1'b0, 32'd0);     // tag 2
        exp_q.push_back(mk(2, 4'd1, 5'd0, 32'd0));
        lsb_valid = 1'b1; lsb_rob_index = 4'd1; lsb_val = 32'hdead;
        tick();
        lsb_valid = 1'b0;
        exp_q.push_back(mk(0, 4'd2, 5'd9, 32'h304));
        alu_write(4'd2, 32'h304, 1'b1, 32'h400);
        checks++; if (rob_to_lsb_store_commit !== 1'b1 || rob_to_lsb_rob_index !== 4'd1 || rob_to_reg_commit !== 1'b0) begin
            errors++; $display("FAIL store: got %b/%0d reg %b expected 1/1 reg 0",
                               rob_to_lsb_store_commit, rob_to_lsb_rob_index, rob_to_reg_commit); end
        tick();
        checks++; if (rob_to_reg_commit !== 1'b1 || rob_clr_out !== 1'b0) begin
            errors++; $display("FAIL branch_link: got reg %b clr %b expected 1/0", rob_to_reg_commit, rob_clr_out); end
        tick();
    endtask

    task automatic test_same_tag();
        do_issue(5'd10, 2'd0, 32'h500, 1'b0, 1'b0, 32'd0);    // tag 3
        alu_valid = 1'b1; alu_rob_index = 4'd3; alu_val = 32'hAAAA; alu_jump = 1'b0;
        lsb_valid = 1'b1; lsb_rob_index = 4'd3; lsb_val = 32'hBBBB;
        dc_rs1_query = 4'd3; #1;
`ifdef ROB_BYPASS_EN
        checks++; if (rob_rs1_ready !== 1'b1 || rob_rs1_val !== 32'hAAAA) begin
            errors++; $display("FAIL bypass: got %b/%h expected 1/0000aaaa", rob_rs1_ready, rob_rs1_val); end
`else
        checks++; if (rob_rs1_ready !== 1'b0) begin errors++; $display("FAIL no_bypass: got %b expected 0", rob_rs1_ready); end
`endif
        exp_q.push_back(mk(0, 4'd3, 5'd10, 32'hAAAA));
        tick();
        alu_valid = 1'b0; lsb_valid = 1'b0;
        tick();
        checks++; if (rob_to_reg_val !== 32'hAAAA) begin errors++; $display("FAIL alu_priority: got %h expected 0000aaaa", rob_to_reg_val); end
        exp_q.push_back(mk(0, 4'd4, 5'd11, 32'h55));
        do_issue(5'd11, 2'd0, 32'h504, 1'b0, 1'b1, 32'h55);   // tag 4, done at issue
        tick();
        checks++; if (rob_to_reg_commit !== 1'b1 || rob_to_reg_rob_index !== 4'd4) begin
            errors++; $display("FAIL issue_done: got %b/%0d expected 1/4", rob_to_reg_commit, rob_to_reg_rob_index); end
        tick();
    endtask

    initial begin
        test_reset();
        test_issue_order();
        test_rdy_hold();
        test_full();
        test_mispredict();
        test_store();
        test_same_tag();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL drain: got %0d outstanding commits expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
